// File: rtl/vga_monitor_pkg.sv
// rtl/vga_monitor_pkg.sv - shared state type and CRC-32/MPEG-2 helpers for the frame signature unit
package vga_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  // One MSB-first shift of the non-reflected CRC register.
  function automatic logic [31:0] crc32_update(input logic [31:0] crc, input logic din);
    logic fb;
    fb = crc[31] ^ din;
    return {crc[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/vga_frame_signature_if.sv
// rtl/vga_frame_signature_if.sv - pixel tap, compare inputs and status outputs of the frame signature unit
interface vga_frame_signature_if #(
  parameter int X_W     = 10,
  parameter int Y_W     = 10,
  parameter int COLOR_W = 8
);
  logic                   enable;
  logic                   pixel_en;
  logic [X_W-1:0]         pixel_x;
  logic [Y_W-1:0]         pixel_y;
  logic [3*COLOR_W-1:0]   rgb;
  logic                   check_en;
  logic [31:0]            expected_sig;
  logic [31:0]            signature;
  logic [7:0]             frame_count;
  logic                   frame_done;
  logic                   step;
  logic                   mismatch;
  logic                   count_error;
  logic                   capture_done;

  modport master (
    output enable, pixel_en, pixel_x, pixel_y, rgb, check_en, expected_sig,
    input  signature, frame_count, frame_done, step, mismatch, count_error, capture_done
  );

  modport slave (
    input  enable, pixel_en, pixel_x, pixel_y, rgb, check_en, expected_sig,
    output signature, frame_count, frame_done, step, mismatch, count_error, capture_done
  );
endinterface

// File: rtl/crc32_parallel.sv
// rtl/crc32_parallel.sv - combinational next CRC-32 after shifting in a DATA_W-bit word, MSB first
module crc32_parallel #(
  parameter int DATA_W = 24
) (
  input  logic [31:0]       i_crc,
  input  logic [DATA_W-1:0] i_data,
  output logic [31:0]       o_crc
);
  import vga_monitor_pkg::*;

  function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [DATA_W-1:0] d);
    logic [31:0] v;
    v = c;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      v = crc32_update(v, d[i]);
    end
    return v;
  endfunction

  assign o_crc = crc_word(i_crc, i_data);

endmodule

// File: rtl/vga_frame_signature.sv
// rtl/vga_frame_signature.sv - per-frame CRC-32 of visible pixels with compare, frame count and step pulse
module vga_frame_signature #(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int COLOR_W         = 8,
  parameter int X_W             = 10,
  parameter int Y_W             = 10,
  parameter int FRAMES_PER_STEP = 1,
  parameter int MAX_FRAMES      = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  vga_frame_signature_if.slave  bus
);
  import vga_monitor_pkg::*;

  localparam int               PIX_W     = $clog2(H_ACTIVE * V_ACTIVE) + 1;
  localparam int               DATA_W    = 3 * COLOR_W;
  localparam logic [X_W-1:0]   X_LIM     = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0]   Y_LIM     = Y_W'(V_ACTIVE);
  localparam logic [PIX_W-1:0] PIX_EXP   = PIX_W'(H_ACTIVE * V_ACTIVE);
  localparam logic [7:0]       MAX_FR    = 8'(MAX_FRAMES);
  localparam logic [15:0]      STEP_LAST = 16'(FRAMES_PER_STEP - 1);

  state_t           r_state;
  state_t           w_state_nx;
  logic [31:0]      r_crc;
  logic [31:0]      w_crc_nx;
  logic [31:0]      r_signature;
  logic [PIX_W-1:0] r_pix_cnt;
  logic [15:0]      r_step_cnt;
  logic [7:0]       r_frame_count;
  logic [7:0]       w_frame_inc;
  logic             r_frame_done;
  logic             r_step;
  logic             r_mismatch;
  logic             r_count_error;
  logic             w_vis;
  logic             w_fe;

  assign w_vis       = bus.pixel_en && (bus.pixel_x < X_LIM) && (bus.pixel_y < Y_LIM);
  assign w_fe        = bus.pixel_en && (bus.pixel_x == '0) && (bus.pixel_y == Y_LIM);
  assign w_frame_inc = r_frame_count + 8'd1;

  crc32_parallel #(.DATA_W(DATA_W)) u_crc (
    .i_crc  (r_crc),
    .i_data (bus.rgb),
    .o_crc  (w_crc_nx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (!bus.enable) begin
      w_state_nx = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nx = SYNC;
        SYNC:    if (w_fe) w_state_nx = CAPTURE;
        CAPTURE: if (w_fe && (MAX_FRAMES != 0) && (w_frame_inc == MAX_FR)) w_state_nx = DONE;
        default: w_state_nx = r_state;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_crc         <= CRC_INIT;
      r_signature   <= '0;
      r_pix_cnt     <= '0;
      r_step_cnt    <= '0;
      r_frame_count <= '0;
      r_frame_done  <= 1'b0;
      r_step        <= 1'b0;
      r_mismatch    <= 1'b0;
      r_count_error <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_step       <= 1'b0;
      if (bus.enable) begin
        case (r_state)
          IDLE: begin
            r_frame_count <= '0;
            r_step_cnt    <= '0;
            r_mismatch    <= 1'b0;
            r_count_error <= 1'b0;
          end
          SYNC: begin
            // The partial frame in flight at arm time is discarded here.
            if (w_fe) begin
              r_crc     <= CRC_INIT;
              r_pix_cnt <= '0;
            end
          end
          CAPTURE: begin
            if (w_vis) begin
              r_crc <= w_crc_nx;
              if (r_pix_cnt != '1) r_pix_cnt <= r_pix_cnt + PIX_W'(1);
            end
            if (w_fe) begin
              r_signature   <= r_crc;
              r_frame_count <= w_frame_inc;
              r_frame_done  <= 1'b1;
              if (r_pix_cnt != PIX_EXP)                        r_count_error <= 1'b1;
              if (bus.check_en && (r_crc != bus.expected_sig)) r_mismatch    <= 1'b1;
              if (r_step_cnt == STEP_LAST) begin
                r_step     <= 1'b1;
                r_step_cnt <= '0;
              end else begin
                r_step_cnt <= r_step_cnt + 16'd1;
              end
              r_crc     <= CRC_INIT;
              r_pix_cnt <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.signature    = r_signature;
  assign bus.frame_count  = r_frame_count;
  assign bus.frame_done   = r_frame_done;
  assign bus.step         = r_step;
  assign bus.mismatch     = r_mismatch;
  assign bus.count_error  = r_count_error;
  assign bus.capture_done = (r_state == DONE);

endmodule

// File: tb/tb_vga_frame_signature.sv
// tb/tb_vga_frame_signature.sv - randomized bench with a frame-level reference model for two unit configurations
module tb_vga_frame_signature;

  localparam int H  = 3;
  localparam int V  = 1;
  localparam int HT = 5;
  localparam int VT = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        pixel_en = 1'b0;
  logic        check_en = 1'b0;
  logic [9:0]  px = '0;
  logic [9:0]  py = '0;
  logic [23:0] rgb = '0;
  logic [31:0] exp_sig = '0;

  always #5 clock = ~clock;

  vga_frame_signature_if #(.X_W(10), .Y_W(10), .COLOR_W(8)) if_a ();
  vga_frame_signature_if #(.X_W(10), .Y_W(10), .COLOR_W(8)) if_b ();

  assign if_a.enable = enable;   assign if_b.enable = enable;
  assign if_a.pixel_en = pixel_en; assign if_b.pixel_en = pixel_en;
  assign if_a.pixel_x = px;      assign if_b.pixel_x = px;
  assign if_a.pixel_y = py;      assign if_b.pixel_y = py;
  assign if_a.rgb = rgb;         assign if_b.rgb = rgb;
  assign if_a.check_en = check_en; assign if_b.check_en = check_en;
  assign if_a.expected_sig = exp_sig; assign if_b.expected_sig = exp_sig;

  vga_frame_signature #(.H_ACTIVE(H), .V_ACTIVE(V), .COLOR_W(8), .X_W(10), .Y_W(10),
                        .FRAMES_PER_STEP(1), .MAX_FRAMES(3)) u_a (
    .clock(clock), .reset(reset), .bus(if_a));

  vga_frame_signature #(.H_ACTIVE(H), .V_ACTIVE(V), .COLOR_W(8), .X_W(10), .Y_W(10),
                        .FRAMES_PER_STEP(2), .MAX_FRAMES(0)) u_b (
    .clock(clock), .reset(reset), .bus(if_b));

  // Reference model: every visible sample is logged; a frame's CRC is computed from its log span.
  logic [23:0] vis_log[$];
  int          m_start[2] = '{0, 0};
  int          m_mode[2]  = '{0, 0};
  int          m_steps[2] = '{0, 0};
  int          m_max[2]   = '{3, 0};
  int          m_fps[2]   = '{1, 2};
  logic [31:0] m_sig[2]   = '{32'h0, 32'h0};
  logic [7:0]  m_fc[2]    = '{8'h0, 8'h0};
  logic        m_fd[2]    = '{1'b0, 1'b0};
  logic        m_st[2]    = '{1'b0, 1'b0};
  logic        m_mm[2]    = '{1'b0, 1'b0};
  logic        m_ce[2]    = '{1'b0, 1'b0};
  logic        m_vis, m_fe;

  function automatic logic [31:0] frame_crc(input int from);
    logic [31:0] c;
    logic [23:0] w;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = from; i < vis_log.size(); i++) begin
      w = vis_log[i];
      for (int b = 23; b >= 0; b--) begin
        fb = c[31] ^ w[b];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ 32'h04C11DB7;
      end
    end
    return c;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        m_mode[d] = 0; m_sig[d] = '0; m_fc[d] = '0; m_fd[d] = 1'b0; m_st[d] = 1'b0;
        m_mm[d] = 1'b0; m_ce[d] = 1'b0; m_steps[d] = 0;
      end
    end else begin
      m_vis = pixel_en && (px < H) && (py < V);
      m_fe  = pixel_en && (px == 0) && (py == V);
      if (m_vis) vis_log.push_back(rgb);
      for (int d = 0; d < 2; d++) begin
        m_fd[d] = 1'b0;
        m_st[d] = 1'b0;
        if (!enable) begin
          m_mode[d] = 0;
        end else if (m_mode[d] == 0) begin
          m_mode[d] = 1; m_fc[d] = '0; m_steps[d] = 0; m_mm[d] = 1'b0; m_ce[d] = 1'b0;
        end else if (m_mode[d] == 1) begin
          if (m_fe) begin m_mode[d] = 2; m_start[d] = vis_log.size(); end
        end else if (m_mode[d] == 2 && m_fe) begin
          m_sig[d] = frame_crc(m_start[d]);
          m_fc[d]  = m_fc[d] + 8'd1;
          m_fd[d]  = 1'b1;
          if (vis_log.size() - m_start[d] != H * V) m_ce[d] = 1'b1;
          if (check_en && m_sig[d] != exp_sig) m_mm[d] = 1'b1;
          m_steps[d]++;
          if (m_steps[d] == m_fps[d]) begin m_st[d] = 1'b1; m_steps[d] = 0; end
          m_start[d] = vis_log.size();
          if (m_max[d] != 0 && m_fc[d] == 8'(m_max[d])) m_mode[d] = 3;
        end
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int fd_a = 0, fd_b = 0, st_a = 0, st_b = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("a.signature",    if_a.signature,            m_sig[0]);
    chk("a.frame_count",  32'(if_a.frame_count),     32'(m_fc[0]));
    chk("a.frame_done",   32'(if_a.frame_done),      32'(m_fd[0]));
    chk("a.step",         32'(if_a.step),            32'(m_st[0]));
    chk("a.mismatch",     32'(if_a.mismatch),        32'(m_mm[0]));
    chk("a.count_error",  32'(if_a.count_error),     32'(m_ce[0]));
    chk("a.capture_done", 32'(if_a.capture_done),    32'(m_mode[0] == 3));
    chk("b.signature",    if_b.signature,            m_sig[1]);
    chk("b.frame_count",  32'(if_b.frame_count),     32'(m_fc[1]));
    chk("b.frame_done",   32'(if_b.frame_done),      32'(m_fd[1]));
    chk("b.step",         32'(if_b.step),            32'(m_st[1]));
    chk("b.mismatch",     32'(if_b.mismatch),        32'(m_mm[1]));
    chk("b.count_error",  32'(if_b.count_error),     32'(m_ce[1]));
    chk("b.capture_done", 32'(if_b.capture_done),    32'(m_mode[1] == 3));
    if (if_a.frame_done === 1'b1) fd_a++;
    if (if_b.frame_done === 1'b1) fd_b++;
    if (if_a.step === 1'b1) st_a++;
    if (if_b.step === 1'b1) st_b++;
  end

  // Raster walker: HT x VT positions, FE at (0, V); optional gaps, glitches and a dropped sample.
  int          rx = 0, ry = 0;
  int          gap_max = 0;
  int          drop_x = -1, drop_y = -1;
  bit          rand_mode = 1'b0;
  logic [23:0] script[$];

  task automatic emit(input logic en, input logic [9:0] x, input logic [9:0] y, input logic [23:0] c);
    @(posedge clock);
    #1;
    pixel_en = en; px = x; py = y; rgb = c;
  endtask

  task automatic tick();
    emit(1'b0, 10'd7, 10'd7, 24'd0);
  endtask

  task automatic step_pos(output bit was_fe);
    logic [23:0] c;
    int          g;
    g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
    repeat (g) emit(1'b0, 10'($urandom_range(1023, 0)), 10'($urandom_range(1023, 0)), 24'($urandom));
    if (rand_mode) begin
      enable = ($urandom_range(39, 0) != 0);
      if ($urandom_range(29, 0) == 0)
        emit(1'b1, 10'($urandom_range(1023, H)), 10'($urandom_range(1023, 0)), 24'($urandom));
    end
    was_fe = (rx == 0 && ry == V);
    if (was_fe && rand_mode) begin
      check_en = 1'($urandom_range(1, 0));
      exp_sig  = ($urandom_range(1, 0) != 0) ? frame_crc(m_start[0]) : $urandom;
    end
    c = 24'($urandom);
    if (rx < H && ry < V && script.size() > 0) c = script.pop_front();
    if (rx == drop_x && ry == drop_y) begin
      emit(1'b0, 10'(rx), 10'(ry), c);
      drop_x = -1;
    end else begin
      emit(1'b1, 10'(rx), 10'(ry), c);
    end
    rx++;
    if (rx == HT) begin rx = 0; ry = (ry + 1) % VT; end
  endtask

  task automatic run_until_fe();
    bit f;
    f = 1'b0;
    while (!f) step_pos(f);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit f;
    vis_log.push_back(24'h313233);
    vis_log.push_back(24'h343536);
    vis_log.push_back(24'h373839);
    chk("model.pin_crc", frame_crc(0), 32'h0376E6E7);
    vis_log.delete();

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset.a.signature",   if_a.signature, 32'h0);
    chk("reset.a.frame_count", 32'(if_a.frame_count), 32'd0);
    chk("reset.a.capture",     32'(if_a.capture_done), 32'd0);
    @(posedge clock);
    #1;
    reset  = 1'b0;
    enable = 1'b1;

    run_until_fe();
    script   = '{24'h313233, 24'h343536, 24'h373839};
    check_en = 1'b1;
    exp_sig  = 32'h0376E6E7;
    run_until_fe();
    tick();
    @(negedge clock);
    chk("dir1.a.signature",  if_a.signature, 32'h0376E6E7);
    chk("dir1.model.sig",    m_sig[0], 32'h0376E6E7);
    chk("dir1.a.frame_done", 32'(if_a.frame_done), 32'd1);
    chk("dir1.a.frame_cnt",  32'(if_a.frame_count), 32'd1);
    chk("dir1.a.mismatch",   32'(if_a.mismatch), 32'd0);
    chk("dir1.a.step",       32'(if_a.step), 32'd1);
    chk("dir1.b.step",       32'(if_b.step), 32'd0);

    script  = '{24'h313233, 24'h343536, 24'h373839};
    exp_sig = 32'h0376E6E6;
    run_until_fe();
    tick();
    @(negedge clock);
    chk("dir2.a.mismatch",   32'(if_a.mismatch), 32'd1);
    chk("dir2.b.step",       32'(if_b.step), 32'd1);

    check_en = 1'b0;
    run_until_fe();
    tick();
    @(negedge clock);
    chk("dir3.a.mismatch_sticky", 32'(if_a.mismatch), 32'd1);
    chk("dir3.a.capture_done",    32'(if_a.capture_done), 32'd1);
    chk("dir3.a.frame_cnt",       32'(if_a.frame_count), 32'd3);

    gap_max = 2;
    run_until_fe();
    run_until_fe();
    tick();
    tick();
    @(negedge clock);
    chk("dir4.a.frame_cnt_frozen", 32'(if_a.frame_count), 32'd3);
    chk("dir4.a.capture_done",     32'(if_a.capture_done), 32'd1);
    chk("dir4.b.frame_cnt",        32'(if_b.frame_count), 32'd5);
    chk("dir4.a.done_pulses",      32'(fd_a), 32'd3);
    chk("dir4.a.step_pulses",      32'(st_a), 32'd3);
    chk("dir4.b.done_pulses",      32'(fd_b), 32'd5);
    chk("dir4.b.step_pulses",      32'(st_b), 32'd2);

    enable = 1'b0;
    tick();
    tick();
    enable = 1'b1;
    run_until_fe();
    drop_x = 1;
    drop_y = 0;
    run_until_fe();
    tick();
    @(negedge clock);
    chk("drop.a.count_error", 32'(if_a.count_error), 32'd1);
    chk("drop.b.count_error", 32'(if_b.count_error), 32'd1);
    chk("drop.a.frame_cnt",   32'(if_a.frame_count), 32'd1);
    run_until_fe();
    tick();
    @(negedge clock);
    chk("drop.a.count_error_sticky", 32'(if_a.count_error), 32'd1);

    while (!(rx == 2 && ry == 0)) step_pos(f);
    @(posedge clock);
    #1;
    reset    = 1'b1;
    pixel_en = 1'b0;
    @(negedge clock);
    chk("rst.a.signature",   if_a.signature, 32'h0);
    chk("rst.a.frame_count", 32'(if_a.frame_count), 32'd0);
    chk("rst.a.mismatch",    32'(if_a.mismatch), 32'd0);
    chk("rst.a.count_error", 32'(if_a.count_error), 32'd0);
    chk("rst.b.signature",   if_b.signature, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    run_until_fe();
    tick();
    @(negedge clock);
    chk("rst.first_fe.a.sig",   if_a.signature, 32'h0);
    chk("rst.first_fe.a.cnt",   32'(if_a.frame_count), 32'd0);
    run_until_fe();
    tick();
    @(negedge clock);
    chk("rst.second_fe.a.cnt",  32'(if_a.frame_count), 32'd1);
    chk("rst.second_fe.a.done", 32'(if_a.frame_done), 32'd1);

    rand_mode = 1'b1;
    gap_max   = 3;
    for (int i = 0; i < 600; i++) begin
      step_pos(f);
      if ($urandom_range(99, 0) == 0) begin
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
      end
    end
    rand_mode = 1'b0;
    enable    = 1'b1;
    repeat (4) tick();
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
